// File: rtl/dbg_mem_scanner.sv
// Sequential debug-port read engine: walks a word range of data memory, streams each
// word out on a valid/ready port and keeps a running modulo-2^DATA_W sum.
`timescale 1ns/1ps
module dbg_mem_scanner #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned CNT_W    = 11,
  parameter int unsigned READ_LAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_e,
  input  logic [DATA_W-1:0] mem_d,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic [DATA_W-1:0] sum
);

  localparam int unsigned LAT_W = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD, DONE} state_t;

  state_t             state, state_nx;
  logic [ADDR_W-1:0]  addr, addr_nx;
  logic [CNT_W-1:0]   remain, remain_nx;
  logic [LAT_W-1:0]   lat_cnt, lat_cnt_nx;
  logic               busy_nx, done_nx, mem_e_nx, out_valid_nx, out_last_nx;
  logic [ADDR_W-1:0]  mem_a_nx, out_addr_nx;
  logic [DATA_W-1:0]  out_data_nx, sum_nx;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      addr      <= '0;
      remain    <= '0;
      lat_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_e     <= 1'b0;
      mem_a     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_last  <= 1'b0;
      sum       <= '0;
    end else begin
      state     <= state_nx;
      addr      <= addr_nx;
      remain    <= remain_nx;
      lat_cnt   <= lat_cnt_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      mem_e     <= mem_e_nx;
      mem_a     <= mem_a_nx;
      out_valid <= out_valid_nx;
      out_data  <= out_data_nx;
      out_addr  <= out_addr_nx;
      out_last  <= out_last_nx;
      sum       <= sum_nx;
    end
  end

  // Next state; status outputs are derived from the next state so they are registered
  always_comb begin
    state_nx    = state;
    addr_nx     = addr;
    remain_nx   = remain;
    lat_cnt_nx  = lat_cnt;
    out_data_nx = out_data;
    out_addr_nx = out_addr;
    out_last_nx = out_last;
    sum_nx      = sum;

    case (state)
      IDLE: begin
        if (start) begin
          sum_nx = '0;
          if (count != '0) begin
            addr_nx    = base_addr;
            remain_nx  = count;
            lat_cnt_nx = '0;
            state_nx   = ISSUE;
          end else begin
            state_nx = DONE;
          end
        end
      end
      ISSUE: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (lat_cnt == LAT_W'(READ_LAT)) begin
          out_data_nx = mem_d;
          out_addr_nx = addr;
          out_last_nx = (remain == CNT_W'(1));
          lat_cnt_nx  = '0;
          state_nx    = HOLD;
        end else begin
          lat_cnt_nx = lat_cnt + LAT_W'(1);
        end
      end
      HOLD: begin
        // abort wins over a simultaneous handshake; that word is not summed
        if (abort) begin
          state_nx = IDLE;
        end else if (out_ready) begin
          sum_nx = sum + out_data;
          if (out_last) begin
            state_nx = DONE;
          end else begin
            addr_nx   = addr + ADDR_W'(1);
            remain_nx = remain - CNT_W'(1);
            state_nx  = ISSUE;
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    busy_nx      = (state_nx != IDLE);
    done_nx      = (state_nx == DONE);
    mem_e_nx     = (state_nx == ISSUE);
    out_valid_nx = (state_nx == HOLD);
    mem_a_nx     = addr_nx;
  end

endmodule

// File: tb/tb_dbg_mem_scanner.sv
// Scoreboard bench for dbg_mem_scanner: one instance with combinational memory read,
// one with a two-cycle registered read, both fed from a shared memory image.
`timescale 1ns/1ps
module tb_dbg_mem_scanner;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 11;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [1024];

  logic              start     [2];
  logic              abort     [2];
  logic [ADDR_W-1:0] base_addr [2];
  logic [CNT_W-1:0]  count     [2];
  logic              out_ready [2];
  logic              busy      [2];
  logic              done      [2];
  logic [ADDR_W-1:0] mem_a     [2];
  logic              mem_e     [2];
  logic              out_valid [2];
  logic [DATA_W-1:0] out_data  [2];
  logic [ADDR_W-1:0] out_addr  [2];
  logic              out_last  [2];
  logic [DATA_W-1:0] sum       [2];

  int done_cnt  [2];
  int mem_e_cnt [2];
  int valid_cnt [2];
  bit toggle_en;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int unsigned LAT = (g == 0) ? 0 : 2;
    logic [DATA_W-1:0] md;
    logic [DATA_W-1:0] p0, p1;
    exp_t q[$];
    logic              prev_valid, prev_ready;
    logic [DATA_W-1:0] prev_data;
    logic [ADDR_W-1:0] prev_addr;
    logic              prev_last;

    if (LAT == 0) begin : gen_comb
      assign md = mem[mem_a[g]];
    end else begin : gen_reg
      always @(posedge clk) begin
        p0 <= mem[mem_a[g]];
        p1 <= p0;
      end
      assign md = p1;
    end

    dbg_mem_scanner #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .READ_LAT(LAT)
    ) u_dut (
      .clk(clk), .rst(rst), .start(start[g]), .abort(abort[g]),
      .base_addr(base_addr[g]), .count(count[g]), .busy(busy[g]), .done(done[g]),
      .mem_a(mem_a[g]), .mem_e(mem_e[g]), .mem_d(md), .out_valid(out_valid[g]),
      .out_ready(out_ready[g]), .out_data(out_data[g]), .out_addr(out_addr[g]),
      .out_last(out_last[g]), .sum(sum[g])
    );

    // Output monitor: pops the scoreboard on each handshake, checks hold stability
    always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
        prev_valid = 1'b0;
      end else begin
        if (done[g])      done_cnt[g]++;
        if (mem_e[g])     mem_e_cnt[g]++;
        if (out_valid[g]) valid_cnt[g]++;
        if (out_valid[g] && prev_valid && !prev_ready) begin
          check($sformatf("stable_data%0d", g), out_data[g], prev_data);
          check($sformatf("stable_addr%0d", g), 32'(out_addr[g]), 32'(prev_addr));
          check($sformatf("stable_last%0d", g), 32'(out_last[g]), 32'(prev_last));
        end
        if (out_valid[g] && out_ready[g] && !abort[g]) begin
          if (q.size() == 0) begin
            check($sformatf("unexpected_word%0d", g), 32'(out_addr[g]), 32'hFFFF_FFFF);
          end else begin
            e = q.pop_front();
            check($sformatf("data%0d", g), out_data[g], e.data);
            check($sformatf("addr%0d", g), 32'(out_addr[g]), 32'(e.addr));
            check($sformatf("last%0d", g), 32'(out_last[g]), 32'(e.last));
          end
        end
        prev_valid = out_valid[g];
        prev_ready = out_ready[g];
        prev_data  = out_data[g];
        prev_addr  = out_addr[g];
        prev_last  = out_last[g];
      end
    end
  end

  task automatic push_exp(input int d, input exp_t e);
    if (d == 0) gen_dut[0].q.push_back(e);
    else        gen_dut[1].q.push_back(e);
  endtask

  function automatic int q_size(input int d);
    return (d == 0) ? gen_dut[0].q.size() : gen_dut[1].q.size();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int d);
    int cyc = 0;
    while (!out_valid[d] && cyc < 50) begin tick(); cyc++; end
    check("valid_timeout", 32'(out_valid[d]), 1);
  endtask

  // One full scan with the scoreboard loaded up front; optional start poke while busy
  task automatic run_scan(input int d, input int base, input int cnt,
                          input logic [31:0] exp_sum, input int exp_first, input bit poke);
    int cyc;
    int done0, mem_e0, valid0;
    bit stray;
    exp_t e;
    for (int i = 0; i < cnt; i++) begin
      e.addr = ADDR_W'((base + i) % 1024);
      e.data = mem[e.addr];
      e.last = (i == cnt - 1);
      push_exp(d, e);
    end
    done0  = done_cnt[d];
    mem_e0 = mem_e_cnt[d];
    valid0 = valid_cnt[d];
    start[d]     = 1'b1;
    base_addr[d] = ADDR_W'(base);
    count[d]     = CNT_W'(cnt);
    tick();
    start[d] = 1'b0;
    if (cnt == 0) begin
      check("zero_done", 32'(done[d]), 1);
    end else begin
      cyc = 1;
      while (!out_valid[d] && cyc < 50) begin tick(); cyc++; end
      check("first_valid", 32'(cyc), 32'(exp_first));
    end
    cyc = 0;
    while (busy[d] && cyc < 500) begin
      if (poke && cyc == 2) begin
        start[d] = 1'b1; base_addr[d] = '0; count[d] = CNT_W'(5);
      end
      if (poke && cyc == 3) start[d] = 1'b0;
      tick();
      cyc++;
    end
    start[d] = 1'b0;
    check("busy_timeout", 32'(busy[d]), 0);
    check("done_pulses", 32'(done_cnt[d] - done0), 1);
    check("sum", sum[d], exp_sum);
    check("queue_drained", 32'(q_size(d)), 0);
    if (cnt == 0) begin
      check("zero_mem_e", 32'(mem_e_cnt[d] - mem_e0), 0);
      check("zero_valid", 32'(valid_cnt[d] - valid0), 0);
    end
    stray = 1'b0;
    repeat (3) begin
      tick();
      stray |= mem_e[d] | out_valid[d] | busy[d] | done[d];
    end
    check("post_idle", 32'(stray), 0);
  endtask

  task automatic check_reset_state(input int d);
    check($sformatf("rst_busy%0d", d),  32'(busy[d]), 0);
    check($sformatf("rst_done%0d", d),  32'(done[d]), 0);
    check($sformatf("rst_mem_e%0d", d), 32'(mem_e[d]), 0);
    check($sformatf("rst_mem_a%0d", d), 32'(mem_a[d]), 0);
    check($sformatf("rst_valid%0d", d), 32'(out_valid[d]), 0);
    check($sformatf("rst_last%0d", d),  32'(out_last[d]), 0);
    check($sformatf("rst_data%0d", d),  out_data[d], 0);
    check($sformatf("rst_oaddr%0d", d), 32'(out_addr[d]), 0);
    check($sformatf("rst_sum%0d", d),   sum[d], 0);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (toggle_en) out_ready[1] = ~out_ready[1];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int done0;
    rst = 1'b0;
    toggle_en = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; abort[d] = 1'b0; base_addr[d] = '0; count[d] = '0;
      out_ready[d] = 1'b1; done_cnt[d] = 0; mem_e_cnt[d] = 0; valid_cnt[d] = 0;
    end
    for (int i = 0; i < 1024; i++) mem[i] = DATA_W'(32'h5A00_0000 + i);
    mem[226] = 10; mem[227] = 5; mem[228] = 2; mem[229] = 0;
    mem[230] = 9;  mem[231] = 7; mem[232] = 0; mem[233] = 2;
    mem[1022] = 1; mem[1023] = 2; mem[0] = 3; mem[1] = 4;
    mem[10] = 32'hFFFF_FFFF; mem[11] = 32'h0000_0002;

    repeat (3) tick();
    check_reset_state(0);
    check_reset_state(1);
    rst = 1'b1;
    tick();

    run_scan(0, 226, 8, 35, 2, 1'b0);

    out_ready[1] = 1'b1;
    toggle_en = 1'b1;
    run_scan(1, 226, 8, 35, 4, 1'b0);
    toggle_en = 1'b0;
    tick();
    out_ready[1] = 1'b1;

    run_scan(0, 1022, 4, 10, 2, 1'b0);
    run_scan(0, 5, 0, 0, 0, 1'b0);
    run_scan(1, 5, 0, 0, 0, 1'b0);
    run_scan(1, 10, 2, 32'h0000_0001, 4, 1'b1);

    // Abort while the third word is held, with a simultaneous ready
    out_ready[0] = 1'b0;
    for (int i = 0; i < 2; i++)
      push_exp(0, '{data: mem[226 + i], addr: ADDR_W'(226 + i), last: 1'b0});
    done0 = done_cnt[0];
    start[0] = 1'b1; base_addr[0] = ADDR_W'(226); count[0] = CNT_W'(8);
    tick();
    start[0] = 1'b0;
    for (int w = 0; w < 2; w++) begin
      wait_valid(0);
      out_ready[0] = 1'b1;
      tick();
      out_ready[0] = 1'b0;
    end
    wait_valid(0);
    check("abort_hold_addr", 32'(out_addr[0]), 228);
    abort[0] = 1'b1;
    out_ready[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    out_ready[0] = 1'b0;
    check("abort_busy", 32'(busy[0]), 0);
    check("abort_valid", 32'(out_valid[0]), 0);
    check("abort_mem_e", 32'(mem_e[0]), 0);
    repeat (2) tick();
    check("abort_no_done", 32'(done_cnt[0] - done0), 0);
    check("abort_sum", sum[0], 15);
    check("abort_queue", 32'(q_size(0)), 0);

    // Reset in the middle of a scan on both instances
    out_ready[0] = 1'b0;
    out_ready[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b1; base_addr[d] = ADDR_W'(226); count[d] = CNT_W'(8);
    end
    tick();
    start[0] = 1'b0;
    start[1] = 1'b0;
    repeat (6) tick();
    check("pre_rst_valid0", 32'(out_valid[0]), 1);
    check("pre_rst_valid1", 32'(out_valid[1]), 1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_state(0);
    check_reset_state(1);
    tick();
    rst = 1'b1;
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    tick();
    run_scan(0, 1022, 4, 10, 2, 1'b0);
    run_scan(1, 226, 8, 35, 4, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
